// File: rtl/tetris_input_ctrl.sv
// Button front end for tetris_game: synchronize, debounce, latch key requests until a game tick.
// Define TETRIS_INPUT_AUTO_REPEAT_EN to add DAS/ARR horizontal auto-repeat.
module tetris_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DAS_TICKS       = 10,
    parameter int ARR_TICKS       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_game,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_rotate,
    input  logic btn_drop,
    output logic key_left,
    output logic key_right,
    output logic key_down,
    output logic key_rotate,
    output logic key_drop
);
    localparam int NB  = 5;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || DAS_TICKS < 1 || ARR_TICKS < 1) begin : g_bad_param
        $error("tetris_input_ctrl: all timing parameters must be >= 1");
    end

    // bit order: 0 left, 1 right, 2 down, 3 rotate, 4 drop
    logic [NB-1:0]  btn_raw;
    logic [NB-1:0]  sync1;
    logic [NB-1:0]  sync2;
    logic [NB-1:0]  stable;
    logic [NB-1:0]  db_flip;
    logic [DBW-1:0] db_cnt [NB];

    assign btn_raw = {btn_drop, btn_rotate, btn_down, btn_right, btn_left};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    always_comb begin
        db_flip = '0;
        for (int i = 0; i < NB; i++) begin
            db_flip[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_flip[i]) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    logic rise_left, rise_right, rise_rotate, rise_drop;
    logic rpt_left, rpt_right;
    logic set_left, set_right;
    logic pend_left, pend_right, pend_rotate, pend_drop;

    assign rise_left   = db_flip[0] & sync2[0];
    assign rise_right  = db_flip[1] & sync2[1];
    assign rise_rotate = db_flip[3] & sync2[3];
    assign rise_drop   = db_flip[4] & sync2[4];

`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
    // state  | meaning
    // IDLE   | no single horizontal direction held
    // DELAY  | one direction held, counting DAS_TICKS before first repeat
    // REPEAT | auto-repeating every ARR_TICKS ticks
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    localparam int RPT_MAX = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
    localparam int CW      = $clog2(RPT_MAX + 1);

    rpt_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dir, dir_nxt;
    logic          rpt_fire;
    logic          held_one;
    logic          held_dir;

    assign held_one = stable[0] ^ stable[1];
    assign held_dir = stable[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        rpt_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (held_one) begin
                    state_nxt = DELAY;
                    cnt_nxt   = '0;
                    dir_nxt   = held_dir;
                end
            end
            DELAY, REPEAT: begin
                // a direction swap drops to IDLE so the new side restarts its DAS
                if (!held_one || held_dir != dir) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (tick_game) begin
                    if (cnt == CW'(((state == DELAY) ? DAS_TICKS : ARR_TICKS) - 1)) begin
                        rpt_fire  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rpt_left  = rpt_fire & ~dir;
    assign rpt_right = rpt_fire & dir;
`else
    assign rpt_left  = 1'b0;
    assign rpt_right = 1'b0;
`endif

    assign set_left  = (rise_left & ~rise_right) | rpt_left;
    assign set_right = (rise_right & ~rise_left) | rpt_right;

    // a new request in the consuming tick cycle wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_left   <= 1'b0;
            pend_right  <= 1'b0;
            pend_rotate <= 1'b0;
            pend_drop   <= 1'b0;
        end else begin
            pend_left   <= (pend_left   & ~tick_game) | set_left;
            pend_right  <= (pend_right  & ~tick_game) | set_right;
            pend_rotate <= (pend_rotate & ~tick_game) | rise_rotate;
            pend_drop   <= (pend_drop   & ~tick_game) | rise_drop;
        end
    end

    assign key_left   = pend_left;
    assign key_right  = pend_right;
    assign key_rotate = pend_rotate;
    assign key_drop   = pend_drop;
    assign key_down   = stable[2];

endmodule
